// File: rtl/d1_pe_ctrl_if.sv
// rtl/d1_pe_ctrl_if.sv - frame control, weight config, sample stream and result handshake bundle
interface d1_pe_ctrl_if;
    logic        start;
    logic        busy;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_y1;
    logic [15:0] res_y2;
    logic [15:0] res_y3;
    logic [15:0] res_y4;
    logic [15:0] res_y5;

    modport master (
        output start, cfg_we, cfg_addr, cfg_data, s_valid, s_data, res_ready,
        input  busy, s_ready, res_valid, res_y1, res_y2, res_y3, res_y4, res_y5
    );

    modport slave (
        input  start, cfg_we, cfg_addr, cfg_data, s_valid, s_data, res_ready,
        output busy, s_ready, res_valid, res_y1, res_y2, res_y3, res_y4, res_y5
    );
endinterface

// File: rtl/d1_pe_ctrl.sv
// rtl/d1_pe_ctrl.sv - sequencer for the 5-tap 1-D convolution PE: weight bank, frame buffer, clear/prime/MAC schedule
module d1_pe_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    d1_pe_ctrl_if.slave bus,
    output logic        pe_reset_n,
    output logic [7:0]  pe_in,
    output logic [2:0]  pe_sel,
    output logic [7:0]  pe_w1,
    output logic [7:0]  pe_w2,
    output logic [7:0]  pe_w3,
    output logic [7:0]  pe_w4,
    output logic [7:0]  pe_w5,
    input  logic [15:0] pe_y1,
    input  logic [15:0] pe_y2,
    input  logic [15:0] pe_y3,
    input  logic [15:0] pe_y4,
    input  logic [15:0] pe_y5
);
    typedef enum logic [2:0] {IDLE, LOAD, CLR, PRIME, MAC, CAP, OUT} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] pe_in_n;
    logic [7:0] w  [0:4];
    logic [7:0] xb [0:8];

    assign pe_w1 = w[0];
    assign pe_w2 = w[1];
    assign pe_w3 = w[2];
    assign pe_w4 = w[3];
    assign pe_w5 = w[4];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (bus.start) begin
                state_n = LOAD;
                cnt_n   = 4'd0;
            end
            LOAD: if (bus.s_valid && bus.s_ready) begin
                if (cnt == 4'd8) begin
                    state_n = CLR;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CLR: if (cnt == 4'd2) begin
                state_n = PRIME;
                cnt_n   = 4'd0;
            end else begin
                cnt_n = cnt + 4'd1;
            end
            PRIME: if (cnt == 4'd4) begin
                state_n = MAC;
                cnt_n   = 4'd0;
            end else begin
                cnt_n = cnt + 4'd1;
            end
            MAC: if (cnt == 4'd4) begin
                state_n = CAP;
                cnt_n   = 4'd0;
            end else begin
                cnt_n = cnt + 4'd1;
            end
            CAP: state_n = OUT;
            OUT: if (bus.res_ready) state_n = IDLE;
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state, so each cycle's PE drive is a pure flop output.
    always_comb begin
        pe_in_n = 8'd0;
        if (state_n == PRIME)
            pe_in_n = xb[cnt_n];
        else if (state_n == MAC && cnt_n <= 4'd3)
            pe_in_n = xb[cnt_n + 4'd5];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bus.busy      <= 1'b0;
            bus.s_ready   <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_y1    <= 16'd0;
            bus.res_y2    <= 16'd0;
            bus.res_y3    <= 16'd0;
            bus.res_y4    <= 16'd0;
            bus.res_y5    <= 16'd0;
            pe_reset_n    <= 1'b0;
            pe_sel        <= 3'd5;
            pe_in         <= 8'd0;
            for (int i = 0; i < 5; i++) w[i] <= 8'd0;
            for (int i = 0; i < 9; i++) xb[i] <= 8'd0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bus.busy      <= (state_n != IDLE);
            bus.s_ready   <= (state_n == LOAD);
            bus.res_valid <= (state_n == OUT);
            // Only the first CLR cycle pulls the PE into reset; the other two cover its reset release.
            pe_reset_n    <= !(state_n == CLR && cnt_n == 4'd0);
            pe_sel        <= (state_n == MAC) ? cnt_n[2:0] : 3'd5;
            pe_in         <= pe_in_n;
            if (state == IDLE && bus.cfg_we && bus.cfg_addr < 3'd5)
                w[bus.cfg_addr] <= bus.cfg_data;
            if (state == LOAD && bus.s_valid && bus.s_ready)
                xb[cnt] <= bus.s_data;
            if (state == CAP) begin
                bus.res_y1 <= pe_y1;
                bus.res_y2 <= pe_y2;
                bus.res_y3 <= pe_y3;
                bus.res_y4 <= pe_y4;
                bus.res_y5 <= pe_y5;
            end
        end
    end
endmodule
